// File: rtl/n101_subsys_bpty_err_ctrl.sv
// Bus-parity error collector: first-error capture, sticky flags, event counter and IRQ/fatal reporting.
// Optional event counter / threshold / fatal path is built only when N101_BPTY_ERR_CNT_EN is defined.
module n101_subsys_bpty_err_ctrl #(
    parameter int unsigned ADDR_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           err_vld,
    input  logic [8:0]           err_kind,
    input  logic [ADDR_SIZE-1:0] err_addr_ilm,
    input  logic [ADDR_SIZE-1:0] err_addr_dlm,
    input  logic [ADDR_SIZE-1:0] err_addr_mem,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [3:0]           paddr,
    input  logic [31:0]          pwdata,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic                 bpty_irq,
    output logic                 bpty_fatal
);

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_CAPADDR = 2'd1;
    localparam logic [1:0] REG_COUNT   = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAPT = 2'd1,
        ST_OVF  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [2:0]             flags;
    logic                   ovf;
    logic [1:0]             cap_src;
    logic [2:0]             cap_kind;
    logic [ADDR_SIZE-1:0]   cap_addr;
    logic                   irq_en;
    logic                   irq_en_nxt;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       threshold;

    logic                   apb_wr;
    logic                   apb_rd;
    logic [1:0]             reg_sel;
    logic                   clr;
    logic                   ctrl_wr;
    logic                   cnt_wr;
    logic                   any_err;
    logic                   multi_err;
    logic                   start_capt;
    logic [1:0]             low_src;
    logic [2:0]             low_kind;
    logic [ADDR_SIZE-1:0]   low_addr;

    assign pready    = 1'b1;
    assign pslverr   = 1'b0;
    assign apb_wr    = psel && penable && pwrite;
    assign apb_rd    = psel && penable && !pwrite;
    assign reg_sel   = paddr[3:2];
    assign clr       = apb_wr && (reg_sel == REG_STATUS) && pwdata[31];
    assign ctrl_wr   = apb_wr && (reg_sel == REG_CTRL);
    assign cnt_wr    = apb_wr && (reg_sel == REG_COUNT);
    assign any_err   = |err_vld;
    assign multi_err = (err_vld[0] && err_vld[1]) || (err_vld[0] && err_vld[2]) ||
                       (err_vld[1] && err_vld[2]);
    // A clear in the same cycle as an error restarts capture with the new event.
    assign start_capt = any_err && (clr || (state == ST_IDLE));
    assign irq_en_nxt = ctrl_wr ? pwdata[0] : irq_en;

    // Lowest-index asserted source wins the capture.
    always_comb begin
        low_src  = 2'd2;
        low_kind = err_kind[8:6];
        low_addr = err_addr_mem;
        if (err_vld[1]) begin
            low_src  = 2'd1;
            low_kind = err_kind[5:3];
            low_addr = err_addr_dlm;
        end
        if (err_vld[0]) begin
            low_src  = 2'd0;
            low_kind = err_kind[2:0];
            low_addr = err_addr_ilm;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start_capt) begin
            state_nxt = multi_err ? ST_OVF : ST_CAPT;
        end else if (any_err) begin
            state_nxt = ST_OVF;
        end else if (clr) begin
            state_nxt = ST_IDLE;
        end
    end

    // Capture FSM, sticky flags and interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            flags    <= 3'd0;
            ovf      <= 1'b0;
            cap_src  <= 2'd0;
            cap_kind <= 3'd0;
            cap_addr <= '0;
            irq_en   <= 1'b0;
            bpty_irq <= 1'b0;
        end else begin
            state  <= state_nxt;
            irq_en <= irq_en_nxt;
            if (start_capt) begin
                flags    <= err_vld;
                ovf      <= multi_err;
                cap_src  <= low_src;
                cap_kind <= low_kind;
                cap_addr <= low_addr;
            end else if (any_err) begin
                flags <= flags | err_vld;
                ovf   <= 1'b1;
            end else if (clr) begin
                flags    <= 3'd0;
                ovf      <= 1'b0;
                cap_src  <= 2'd0;
                cap_kind <= 3'd0;
                cap_addr <= '0;
            end
            // Rises together with the capture; across a clear it drops one cycle after the state.
            bpty_irq <= ((state_nxt != ST_IDLE) || (state != ST_IDLE)) && irq_en_nxt;
        end
    end

`ifdef N101_BPTY_ERR_CNT_EN
    logic [1:0]       err_pop;
    logic [CNT_W:0]   cnt_sum;
    logic [14:0]      unused_pwdata;

    assign err_pop       = 2'(err_vld[0]) + 2'(err_vld[1]) + 2'(err_vld[2]);
    assign cnt_sum       = {1'b0, count} + (CNT_W + 1)'(err_pop);
    assign unused_pwdata = pwdata[30:16];

    // Saturating event counter; fatal compares the registered count so it lags by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            threshold  <= '0;
            bpty_fatal <= 1'b0;
        end else begin
            if (cnt_wr) begin
                count <= pwdata[CNT_W-1:0];
            end else if (cnt_sum[CNT_W]) begin
                count <= '1;
            end else begin
                count <= cnt_sum[CNT_W-1:0];
            end
            if (ctrl_wr) begin
                threshold <= pwdata[15:8];
            end
            if ((threshold != '0) && (count >= threshold)) begin
                bpty_fatal <= 1'b1;
            end
        end
    end
`else
    logic [29:0] unused_pwdata;
    logic        unused_cnt_wr;

    assign unused_pwdata = pwdata[30:1];
    assign unused_cnt_wr = cnt_wr;
    assign count         = '0;
    assign threshold     = '0;
    assign bpty_fatal    = 1'b0;
`endif

    logic [1:0] unused_paddr;
    assign unused_paddr = paddr[1:0];

    // Zero-wait read mux; bus is quiet outside the read access phase.
    always_comb begin
        prdata = 32'd0;
        if (apb_rd) begin
            case (reg_sel)
                REG_STATUS:  prdata = 32'({2'(state), cap_kind, cap_src, ovf, flags});
                REG_CAPADDR: prdata = 32'(cap_addr);
                REG_COUNT:   prdata = 32'(count);
                REG_CTRL:    prdata = {16'd0, threshold, 7'd0, irq_en};
                default:     prdata = 32'd0;
            endcase
        end
    end

endmodule
